// File: rtl/bus_demultiplexer.sv
// bus_demultiplexer: registered 1-to-N demultiplexer with a one-entry holding register per channel
//   Ports:
//     clk          rising-edge clock
//     reset_n      asynchronous active-low reset
//     inBroadcast  (only with BUS_DEMUX_BROADCAST_EN) load every channel, ignoring inSelect
//     inData       producer data word
//     inSelect     destination channel index
//     inValid      producer has a word to transfer
//     inReady      block accepts the word this cycle
//     outData      flattened channel data; channel i at [i*dataWidth +: dataWidth]
//     outValid     per-channel holding register full
//     outReady     per-channel consumer accepts
//     acceptCount  accepted input transfers, wraps modulo 256
//   Optional feature macro: BUS_DEMUX_BROADCAST_EN
module bus_demultiplexer #(
    parameter int dataWidth = 8,
    parameter int selWidth = 2,
    localparam int numOutputs = 2 ** selWidth
) (
    input  logic                             clk,
    input  logic                             reset_n,
`ifdef BUS_DEMUX_BROADCAST_EN
    input  logic                             inBroadcast,
`endif
    input  logic [dataWidth-1:0]             inData,
    input  logic [selWidth-1:0]              inSelect,
    input  logic                             inValid,
    output logic                             inReady,
    output logic [numOutputs*dataWidth-1:0]  outData,
    output logic [numOutputs-1:0]            outValid,
    input  logic [numOutputs-1:0]            outReady,
    output logic [7:0]                       acceptCount
);
    // a channel can take a word if it is empty or being drained at the same edge
    logic [numOutputs-1:0] free;
    logic [numOutputs-1:0] load;
    logic                  accept;
    always_comb begin
        free = ~outValid | outReady;
`ifdef BUS_DEMUX_BROADCAST_EN
        load = inBroadcast ? '1 : numOutputs'(1) << inSelect;
        inReady = inBroadcast ? &free : free[inSelect];
`else
        load = numOutputs'(1) << inSelect;
        inReady = free[inSelect];
`endif
        accept = inValid && inReady;
    end
    // a fill wins over a drain on the same channel, so valid stays set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid <= '0;
            outData <= '0;
            acceptCount <= '0;
        end else begin
            if (accept)
                acceptCount <= acceptCount + 8'd1;
            for (int i = 0; i < numOutputs; i++) begin
                if (accept && load[i]) begin
                    outData[i*dataWidth +: dataWidth] <= inData;
                    outValid[i] <= 1'b1;
                end else if (outReady[i]) begin
                    outValid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_demultiplexer.sv
// tb_bus_demultiplexer: randomized scoreboard bench for bus_demultiplexer
module tb_bus_demultiplexer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        inBroadcast = 1'b0;
    logic [7:0]  inData = '0;
    logic [1:0]  inSelect = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] outData;
    logic [3:0]  outValid;
    logic [3:0]  outReady = '0;
    logic [7:0]  acceptCount;

    bus_demultiplexer dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef BUS_DEMUX_BROADCAST_EN
        .inBroadcast(inBroadcast),
`endif
        .inData(inData),
        .inSelect(inSelect),
        .inValid(inValid),
        .inReady(inReady),
        .outData(outData),
        .outValid(outValid),
        .outReady(outReady),
        .acceptCount(acceptCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] q [4][$];
    logic [7:0] exp_cnt = '0;
    bit mon_en = 1'b0;
`ifdef BUS_DEMUX_BROADCAST_EN
    localparam bit bc_build = 1'b1;
`else
    localparam bit bc_build = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // a channel is full exactly when its scoreboard queue holds a word
    function automatic bit ch_free(input int c, input logic [3:0] rdy);
        return q[c].size() == 0 || rdy[c];
    endfunction

    task automatic cycle(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] rdy, input logic bc);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        #1;
        inValid = v;
        inSelect = sel;
        inData = d;
        outReady = rdy;
        inBroadcast = bc;
        #2;
        if (bc_build && bc)
            exp_rdy = ch_free(0, rdy) && ch_free(1, rdy) && ch_free(2, rdy) && ch_free(3, rdy);
        else
            exp_rdy = ch_free(int'(sel), rdy);
        chk("inReady", int'(inReady), int'(exp_rdy));
        chk("acceptCount", int'(acceptCount), int'(exp_cnt));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_cnt = exp_cnt + 8'd1;
            for (int c = 0; c < 4; c++)
                if ((bc_build && bc) || c == int'(sel))
                    q[c].push_back(d);
        end
    endtask

    // outputs are sampled just before the edge; a drain retires the oldest held word
    always begin
        @(negedge clk);
        #4;
        if (mon_en) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("outValid[%0d]", c), int'(outValid[c]), int'(q[c].size() != 0));
                if (q[c].size() != 0) begin
                    chk($sformatf("outData[%0d]", c), int'(outData[c*8 +: 8]), int'(q[c][0]));
                    if (outReady[c])
                        void'(q[c].pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        inValid = 1'b1;
        inSelect = 2'd1;
        inData = 8'h55;
        outReady = '0;
        reset_n = 1'b0;
        #1;
        chk("rst_outValid_async", int'(outValid), 0);
        chk("rst_count_async", int'(acceptCount), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outValid_held", int'(outValid), 0);
        chk("rst_outData_held", int'(outData), 0);
        chk("rst_count_held", int'(acceptCount), 0);
        for (int c = 0; c < 4; c++)
            q[c].delete();
        exp_cnt = '0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        inValid = 1'b0;
        #1;
        chk("rst_inReady", int'(inReady), 1);
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();
        // single route and hold
        cycle(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0);
        repeat (5) cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        // backpressure, then retarget while stalled
        cycle(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0);
        cycle(1'b1, 2'd1, 8'h3C, 4'b0000, 1'b0);
        cycle(1'b1, 2'd1, 8'h3C, 4'b0000, 1'b0);
        cycle(1'b1, 2'd3, 8'h3C, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        // streaming at full throughput
        do_reset();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 2'd0, 8'(i), 4'b0001, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
        chk("stream_count", int'(acceptCount), 10);
        // random traffic long enough to wrap the counter several times
        for (int i = 0; i < 1200; i++)
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom), 1'b0);
`ifdef BUS_DEMUX_BROADCAST_EN
        do_reset();
        cycle(1'b1, 2'd2, 8'h44, 4'b0000, 1'b0);
        cycle(1'b1, 2'd0, 8'h7E, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 8'h7E, 4'b0100, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        chk("bc_outValid", int'(outValid), 15);
        chk("bc_count", int'(acceptCount), 2);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) == 0));
`endif
        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 2'($urandom), 8'($urandom), 4'b0000, 1'b0);
        do_reset();
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
